sound_event_player: RTL and testbench
=====================================

Name: sound_event_player

Overview:
- Audio stage downstream of the collision detector and the direction pushbuttons in the snake game.
- Converts single game events into short square-wave note sequences on an 8-bit output. The output drives the board's left[7:0] pins or an external DAC.
  - goodColl: apple eaten.
  - badColl: death.
  - direction press: click.
- Events have fixed priorities. A higher-priority event preempts the sequence that is playing.

Parameters:
- CLK_HZ, 12_000_000, clock frequency in Hz. All note periods and durations derive from it.
- VOLUME, 8'hFF, output level while the square wave is high.

Ports:
- clk  input  1  system clock (hwclk)
- nrst  input  1  asynchronous active-low reset
- enable  input  1  1 = sound allowed; 0 = mute and abort
- goodColl  input  1  synchronous collision flag from collision block; rising edge = event
- badColl  input  1  synchronous collision flag; rising edge = event
- direction_i  input  4  raw pushbuttons {up, down, left, right}; any bit rising = click event
- soundOut  output  8  registered audio sample: VOLUME or 0
- busy  output  1  1 while any sequence is playing
- playing_id  output  2  0 none, 1 click, 2 good, 3 bad

Behaviour:
- Reset values:
  - Asynchronous on nrst low: soundOut=0, busy=0, playing_id=0, state IDLE.
  - All counters, phase, edge registers and synchronizer flops reset to 0.
- Inputs:
  - direction_i passes through a 2-FF synchronizer per bit, then rising-edge detection against a previous-value register.
  - goodColl and badColl are already synchronous. They get rising-edge detection only, with no synchronizer.
  - A level held high produces exactly one event.
- Note constants, all integer division rounding down:
  - HALF(f) = CLK_HZ/(2*f).
  - DUR(ms) = (CLK_HZ/1000)*ms.
- Sequences:
  - CLICK: 1760 Hz for 10 ms.
  - GOOD_N1: 880 Hz for 60 ms, then GOOD_N2: 1320 Hz for 60 ms.
  - BAD_N1: 440 Hz for 150 ms, then BAD_N2: 330 Hz for 150 ms, then BAD_N3: 220 Hz for 150 ms.
  - After the last note of any sequence, return to IDLE.
- States: IDLE, CLICK, GOOD_N1, GOOD_N2, BAD_N1, BAD_N2, BAD_N3.
- Priority: bad > good > click.
  - A bad event always (re)starts BAD_N1, from any state.
  - A good event (re)starts GOOD_N1 from IDLE, CLICK, GOOD_N1 or GOOD_N2. It is ignored during BAD_*.
  - A click event (re)starts CLICK from IDLE or CLICK. It is ignored otherwise.
  - Simultaneous events: only the highest priority is taken.
- Note entry, on the edge that enters any note state:
  - Duration counter and half-period counter clear.
  - phase is set to 1.
  - soundOut becomes VOLUME in the following cycle, with no extra latency.
  - Example: goodColl rising sampled at edge k gives soundOut=VOLUME, busy=1 and playing_id=2 after edge k.
- Within a note:
  - The half-period counter counts 0..HALF-1. At HALF-1 it wraps to 0 and phase toggles.
  - The duration counter counts 0..DUR-1. At DUR-1 it advances to the next note, or to IDLE.
  - A note occupies exactly DUR cycles.
- Output rules:
  - soundOut = VOLUME when phase=1 and state is not IDLE; otherwise 0.
  - busy = (state != IDLE).
  - playing_id is registered together with the state.
  - In IDLE, soundOut=0 and phase=0.
- enable low:
  - On the next edge, state goes to IDLE and all outputs go to 0.
  - Events arriving while enable=0 are discarded. Edge registers still track the inputs, so raising enable while an input is high produces no event.
- Counter widths must hold the largest DUR at the default CLK_HZ: 150 ms at 12 MHz = 1_800_000 cycles, 21 bits.
- Reset mid-sequence: immediate IDLE. No event is replayed after reset releases.

Test Plan (CLK_HZ=100_000: HALF 880=56, 1320=37, 440=113, 330=151, 220=227, 1760=28; DUR 10ms=1000, 60ms=6000, 150ms=15000):
- Apple chirp: goodColl pulse for 1 cycle.
  - soundOut=FF for 56 cycles, then 00 for 56 cycles, repeating.
  - After 6000 cycles the half-period becomes 37.
  - busy=0, playing_id=0 and soundOut=0 exactly 12000 cycles after start.
- Death: badColl rising while in GOOD_N2.
  - Next cycle: playing_id=3 and soundOut=FF.
  - Half-periods 113 / 151 / 227, each note lasting 15000 cycles; idle after 45000 cycles.
- Priority: goodColl rising at 5000 cycles into BAD_N1 -> ignored (playing_id stays 3). badColl and goodColl rising in the same cycle from IDLE -> BAD_N1.
- Click: direction_i[2] rising from IDLE -> soundOut=FF 3 cycles after the input change (2 sync + 1). Half-period 28, 1000 cycles total. direction_i held high for 5000 cycles -> only one click.
- Mute: enable=0 during GOOD_N1 -> next cycle soundOut=0, busy=0. A goodColl pulse while enable=0 -> no sound after enable returns to 1.
- Async reset: nrst low mid BAD_N2, asserted between clock edges -> outputs 0 immediately. After release: IDLE, no output until a new event.

Source files
------------

// File: rtl/sound_event_player.sv
// sound_event_player: turns click/apple/death game events into prioritised square-wave note sequences.
module sound_event_player #(
  parameter int          CLK_HZ = 12_000_000,
  parameter logic [7:0]  VOLUME = 8'hFF
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       enable,
  input  logic       goodColl,
  input  logic       badColl,
  input  logic [3:0] direction_i,
  output logic [7:0] soundOut,
  output logic       busy,
  output logic [1:0] playing_id
);
  typedef enum logic [2:0] {IDLE, CLICK, GOOD_N1, GOOD_N2, BAD_N1, BAD_N2, BAD_N3} state_t;
  localparam logic [20:0] H1760 = 21'(CLK_HZ / (2 * 1760));
  localparam logic [20:0] H1320 = 21'(CLK_HZ / (2 * 1320));
  localparam logic [20:0] H880  = 21'(CLK_HZ / (2 * 880));
  localparam logic [20:0] H440  = 21'(CLK_HZ / (2 * 440));
  localparam logic [20:0] H330  = 21'(CLK_HZ / (2 * 330));
  localparam logic [20:0] H220  = 21'(CLK_HZ / (2 * 220));
  localparam logic [20:0] D10   = 21'((CLK_HZ / 1000) * 10);
  localparam logic [20:0] D60   = 21'((CLK_HZ / 1000) * 60);
  localparam logic [20:0] D150  = 21'((CLK_HZ / 1000) * 150);
  state_t      state, state_n, nxt, tgt;
  logic        phase, phase_n, start, is_bad;
  logic [20:0] hcnt, hcnt_n, dcnt, dcnt_n, half, dur;
  logic [3:0]  d_s1, d_s2, d_prev;
  logic        good_prev, bad_prev, good_ev, bad_ev, click_ev;
  logic [1:0]  id_n;
  assign good_ev  = goodColl & ~good_prev;
  assign bad_ev   = badColl & ~bad_prev;
  assign click_ev = |(d_s2 & ~d_prev);
  assign is_bad   = state == BAD_N1 || state == BAD_N2 || state == BAD_N3;
  always_comb begin
    half = H1760;
    dur  = D10;
    nxt  = IDLE;
    case (state)
      GOOD_N1: begin half = H880;  dur = D60;  nxt = GOOD_N2; end
      GOOD_N2: begin half = H1320; dur = D60;  nxt = IDLE;    end
      BAD_N1:  begin half = H440;  dur = D150; nxt = BAD_N2;  end
      BAD_N2:  begin half = H330;  dur = D150; nxt = BAD_N3;  end
      BAD_N3:  begin half = H220;  dur = D150; nxt = IDLE;    end
      default: ;
    endcase
  end
  // Events are only honoured while enabled; priority bad > good > click.
  always_comb begin
    start   = enable && (bad_ev || (good_ev && !is_bad) || (click_ev && (state == IDLE || state == CLICK)));
    tgt     = bad_ev ? BAD_N1 : (good_ev && !is_bad) ? GOOD_N1 : CLICK;
    state_n = state;
    phase_n = phase;
    hcnt_n  = hcnt + 21'd1;
    dcnt_n  = dcnt + 21'd1;
    if (!enable || (state == IDLE && !start)) begin
      state_n = IDLE;
      phase_n = 1'b0;
      hcnt_n  = '0;
      dcnt_n  = '0;
    end else if (start) begin
      state_n = tgt;
      phase_n = 1'b1;
      hcnt_n  = '0;
      dcnt_n  = '0;
    end else if (dcnt == dur - 21'd1) begin
      state_n = nxt;
      phase_n = nxt != IDLE;
      hcnt_n  = '0;
      dcnt_n  = '0;
    end else if (hcnt == half - 21'd1) begin
      phase_n = ~phase;
      hcnt_n  = '0;
    end
    id_n = state_n == IDLE ? 2'd0 : state_n == CLICK ? 2'd1 : (state_n == GOOD_N1 || state_n == GOOD_N2) ? 2'd2 : 2'd3;
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      d_s1       <= '0;
      d_s2       <= '0;
      d_prev     <= '0;
      good_prev  <= 1'b0;
      bad_prev   <= 1'b0;
      state      <= IDLE;
      phase      <= 1'b0;
      hcnt       <= '0;
      dcnt       <= '0;
      soundOut   <= '0;
      busy       <= 1'b0;
      playing_id <= '0;
    end else begin
      d_s1       <= direction_i;
      d_s2       <= d_s1;
      d_prev     <= d_s2;
      good_prev  <= goodColl;
      bad_prev   <= badColl;
      state      <= state_n;
      phase      <= phase_n;
      hcnt       <= hcnt_n;
      dcnt       <= dcnt_n;
      soundOut   <= (phase_n && state_n != IDLE) ? VOLUME : 8'h00;
      busy       <= state_n != IDLE;
      playing_id <= id_n;
    end
  end
endmodule

// File: tb/tb_sound_event_player.sv
// tb_sound_event_player: scoreboard bench; expected samples are queued from note tables and compared every cycle.
module tb_sound_event_player;
  logic       clk = 0, nrst = 0, enable = 1, goodColl = 0, badColl = 0;
  logic [3:0] direction_i = '0;
  logic [7:0] soundOut;
  logic       busy;
  logic [1:0] playing_id;
  int checks = 0, errors = 0;
  string cur = "reset";
  typedef struct packed {logic [7:0] s; logic b; logic [1:0] id;} smp_t;
  smp_t q[$];
  sound_event_player #(.CLK_HZ(100_000), .VOLUME(8'hFF)) dut (
    .clk(clk), .nrst(nrst), .enable(enable), .goodColl(goodColl), .badColl(badColl),
    .direction_i(direction_i), .soundOut(soundOut), .busy(busy), .playing_id(playing_id)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got snd=%h busy=%b id=%0d, expected snd=%h busy=%b id=%0d",
               tag, $time, got[10:3], got[2], got[1:0], exp[10:3], exp[2], exp[1:0]);
    end
  endtask
  task automatic push_note(input int half, input int n, input logic [1:0] id);
    smp_t e;
    for (int i = 0; i < n; i++) begin
      e.s  = ((i / half) % 2 == 0) ? 8'hFF : 8'h00;
      e.b  = 1'b1;
      e.id = id;
      q.push_back(e);
    end
  endtask
  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) q.push_back('0);
  endtask
  task automatic drain(input int n);
    smp_t e;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      @(posedge clk);
      #1;
      e = q.pop_front();
      check(cur, {soundOut, busy, playing_id}, e);
    end
  endtask
  task automatic drain_all();
    drain(q.size());
  endtask
  initial begin
    #3;
    check("reset_snd", {soundOut, 3'b0}, 11'h0);
    check("reset_busy", {10'h0, busy}, 11'h0);
    check("reset_id", {9'h0, playing_id}, 11'h0);
    #4 nrst = 1;
    @(posedge clk); #1;
    cur = "apple";
    goodColl = 1;
    push_note(56, 6000, 2); push_note(37, 6000, 2); push_idle(5);
    drain(1); goodColl = 0; drain_all();
    cur = "death";
    goodColl = 1;
    push_note(56, 6000, 2); push_note(37, 100, 2);
    drain(1); goodColl = 0; drain_all();
    badColl = 1;
    push_note(113, 15000, 3); push_note(151, 15000, 3); push_note(227, 15000, 3); push_idle(5);
    drain(1); badColl = 0; drain(4999);
    cur = "good_ignored";
    goodColl = 1; drain(1); goodColl = 0; drain_all();
    cur = "simultaneous";
    badColl = 1; goodColl = 1;
    push_note(113, 200, 3);
    drain(1); badColl = 0; goodColl = 0; drain_all();
    enable = 0; push_idle(3); drain_all(); enable = 1;
    cur = "click";
    direction_i = 4'b0100;
    push_idle(2); push_note(28, 1000, 1); push_idle(4000);
    drain_all();
    direction_i = 4'b0000; push_idle(5); drain_all();
    cur = "mute";
    goodColl = 1;
    push_note(56, 300, 2);
    drain(1); goodColl = 0; drain_all();
    enable = 0; push_idle(3);
    drain(1); goodColl = 1; drain(1); goodColl = 0; drain(1);
    enable = 1; push_idle(20); drain_all();
    cur = "mute_held";
    enable = 0; goodColl = 1; push_idle(2); drain_all();
    enable = 1; push_idle(10); drain_all(); goodColl = 0;
    cur = "async_reset";
    badColl = 1;
    push_note(113, 15000, 3); push_note(151, 500, 3);
    drain(1); badColl = 0; drain_all();
    #3 nrst = 0;
    #1 check("async_reset_now", {soundOut, busy, playing_id}, 11'h0);
    @(posedge clk); #3 nrst = 1;
    cur = "after_reset";
    push_idle(20); drain_all();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
